mult_arbiter: RTL

- Shares one `mult` unit (8x8 -> 16, active-low `rst_i`, `start_i`/`ready_o` handshake) between N_REQ requesters, e.g. `cub` and a square-root unit.
- Round-robin arbitration; operands are latched at grant.
- Runs the mult reset/start/clear/wait sequence on behalf of the winner and returns the product with a done pulse.
- A watchdog aborts any multiply that never completes.
- Sits beside `mult` in the datapath top; `mult` is instantiated at the top and wired to the m_* ports.

---
 rtl/mult_arbiter_pkg.sv | 21 ++
 rtl/mult_arbiter_if.sv | 19 +
 rtl/mult_arbiter_rr_pick.sv | 26 ++
 rtl/mult_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared state encoding, defaults and helpers for the multiplier arbiter.
package mult_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MRST   = 3'd1,
    MSTART = 3'd2,
    MCLR   = 3'd3,
    WAIT   = 3'd4
  } arb_state_e;

  localparam int TIMEOUT_DEF = 64;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    oh2idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) oh2idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bus of the multiplier arbiter: packed requests/operands in, grant/done/product out.
interface mult_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int W     = 8
);
  logic [N_REQ-1:0]   req_i;
  logic [N_REQ*W-1:0] a_bi;
  logic [N_REQ*W-1:0] b_bi;
  logic [N_REQ-1:0]   gnt_o;
  logic [N_REQ-1:0]   done_o;
  logic [2*W-1:0]     y_bo;
  logic               err_o;
  logic               busy_o;

  modport master (output req_i, a_bi, b_bi,
                  input  gnt_o, done_o, y_bo, err_o, busy_o);
  modport slave  (input  req_i, a_bi, b_bi,
                  output gnt_o, done_o, y_bo, err_o, busy_o);
endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found searching upward from last+1, wrapping.
module mult_arbiter_rr_pick #(
  parameter int N_REQ = 2,
  parameter int LW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [N_REQ-1:0] win
);

  logic [N_REQ-1:0] rot;
  int               idx;

  // Walk from the farthest candidate back to the nearest so the nearest one overwrites.
  always_comb begin
    win = '0;
    rot = '0;
    idx = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % N_REQ;
      rot = req >> idx;
      if (rot[0]) win = N_REQ'(1) << idx;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that runs the shared mult reset/start/clear/wait sequence for the winning requester.
//   state  | meaning
//   IDLE   | waiting for a request; arbitrates and latches operands
//   MRST   | mult held in reset, start asserted; grant pulse visible
//   MSTART | mult out of reset, start still asserted
//   MCLR   | start dropped, watchdog cleared
//   WAIT   | waiting for mult ready or watchdog expiry
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int W       = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mult_arbiter_if.slave  bus,
  output logic           m_rst_o,
  output logic           m_start_o,
  output logic [W-1:0]   m_a_bo,
  output logic [W-1:0]   m_b_bo,
  input  logic           m_ready_i,
  input  logic [2*W-1:0] m_y_bi
);

  localparam int              LW       = (N_REQ > 2) ? 2 : 1;
  localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT - 1);
  localparam logic [LW-1:0]   LAST_RST = LW'(N_REQ - 1);

  arb_state_e       state;
  logic [LW-1:0]    last;
  logic [LW-1:0]    win_idx;
  logic [N_REQ-1:0] win;
  logic [N_REQ-1:0] cur;
  logic [WD_W-1:0]  wd;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;

  mult_arbiter_rr_pick #(.N_REQ(N_REQ), .LW(LW)) u_pick (
    .req  (bus.req_i),
    .last (last),
    .win  (win)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        sel_a = bus.a_bi[i*W +: W];
        sel_b = bus.b_bi[i*W +: W];
      end
    end
  end

  assign win_idx   = LW'(oh2idx(4'(win)));
  assign m_rst_o   = (state != MRST);
  assign m_start_o = (state == MRST) || (state == MSTART);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      last       <= LAST_RST;
      cur        <= '0;
      wd         <= '0;
      m_a_bo     <= '0;
      m_b_bo     <= '0;
      bus.gnt_o  <= '0;
      bus.done_o <= '0;
      bus.y_bo   <= '0;
      bus.err_o  <= 1'b0;
      bus.busy_o <= 1'b0;
    end else begin
      bus.gnt_o  <= '0;
      bus.done_o <= '0;
      bus.err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_i != '0) begin
            m_a_bo     <= sel_a;
            m_b_bo     <= sel_b;
            last       <= win_idx;
            cur        <= win;
            bus.gnt_o  <= win;
            bus.busy_o <= 1'b1;
            state      <= MRST;
          end
        end
        MRST:   state <= MSTART;
        MSTART: state <= MCLR;
        MCLR: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (m_ready_i) begin
            bus.y_bo   <= m_y_bi;
            bus.done_o <= cur;
            bus.busy_o <= 1'b0;
            state      <= IDLE;
          end else if (wd == WD_MAX) begin
            // Abort: the requester still gets its done, flagged with err and a zero product.
            bus.y_bo   <= '0;
            bus.done_o <= cur;
            bus.err_o  <= 1'b1;
            bus.busy_o <= 1'b0;
            state      <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
